// File: rtl/dds_sinusoid.sv
// Runtime-tunable DDS oscillator: phase accumulator, quarter-wave sine LUT, four waveforms.
// Optional output gain stage under DDS_SINUSOID_GAIN_EN (adds gain_i and one pipeline stage).
module dds_sinusoid #(
  parameter int unsigned width_p          = 12,
  parameter int unsigned phase_width_p    = 24,
  parameter int unsigned lut_addr_width_p = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic [phase_width_p-1:0]        tuning_word_i,
  input  logic [1:0]                      wave_sel_i,
  input  logic                            sync_i,
  input  logic                            ready_i,
`ifdef DDS_SINUSOID_GAIN_EN
  input  logic [7:0]                      gain_i,
`endif
  output logic                            valid_o,
  output logic signed [width_p-1:0]       data_o
);

  localparam int unsigned LutDepth = 1 << lut_addr_width_p;
  localparam int          MaxAmp   = (2 ** (width_p - 1)) - 1;
  localparam real         HalfPi   = 1.5707963267948966;
  localparam logic [width_p-1:0] MaxAmpW = {1'b0, {(width_p - 1){1'b1}}};

  // Half-step sample points make LUT[~idx] the exact mirror of LUT[idx].
  logic [width_p-2:0] lut [LutDepth];
  for (genvar k = 0; k < LutDepth; k++) begin : g_lut
    localparam real Ang = HalfPi * (real'(k) + 0.5) / real'(LutDepth);
    localparam int  Val = $rtoi(real'(MaxAmp) * $sin(Ang) + 0.5);
    assign lut[k] = (width_p - 1)'(Val);
  end

  logic                        advance;
  logic [phase_width_p-1:0]    phase_q, phase_d;
  logic [1:0]                  q_r;
  logic [lut_addr_width_p-1:0] idx_r, addr_r;

  // Stage A keeps only the top width_p+1 phase bits: quadrant plus triangle/saw field.
  logic [width_p:0]            phase_a_q;
  logic [1:0]                  sel_a_q;
  logic [width_p-2:0]          lut_a_q;
  logic                        valid_a_q;

  logic [1:0]                  q_a;
  logic [width_p-2:0]          u_a;
  logic [width_p-1:0]          mag_a, sample_a;

  logic                        valid_q;
  logic signed [width_p-1:0]   data_q, data_d;

  assign advance = ~valid_q | ready_i;

  assign q_r    = phase_q[phase_width_p-1 -: 2];
  assign idx_r  = phase_q[phase_width_p-3 -: lut_addr_width_p];
  assign addr_r = q_r[0] ? ~idx_r : idx_r;

  always_comb begin
    phase_d = phase_q;
    if (sync_i) begin
      phase_d = '0;
    end else if (advance) begin
      phase_d = phase_q + tuning_word_i;
    end
  end

  assign q_a = phase_a_q[width_p -: 2];
  assign u_a = phase_a_q[width_p-2:0];

  always_comb begin
    mag_a    = '0;
    sample_a = '0;
    case (sel_a_q)
      2'd0: begin
        mag_a    = {1'b0, lut_a_q};
        sample_a = q_a[1] ? -mag_a : mag_a;
      end
      2'd1: begin
        sample_a = phase_a_q[width_p] ? -MaxAmpW : MaxAmpW;
      end
      2'd2: begin
        sample_a = {~phase_a_q[width_p], phase_a_q[width_p-1:1]};
      end
      default: begin
        mag_a    = {1'b0, (q_a[0] ? ~u_a : u_a)};
        sample_a = q_a[1] ? -mag_a : mag_a;
      end
    endcase
  end

`ifdef DDS_SINUSOID_GAIN_EN
  logic signed [width_p-1:0] samp_b_q;
  logic                      valid_b_q;
  logic signed [width_p+7:0] prod;

  // Product fits in width_p+8 bits since |sample| <= 2^(w-1) and gain <= 255.
  assign prod   = samp_b_q * $signed({1'b0, gain_i});
  assign data_d = prod[width_p+7:8];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      samp_b_q  <= '0;
      valid_b_q <= 1'b0;
    end else if (advance) begin
      samp_b_q  <= sample_a;
      valid_b_q <= valid_a_q;
    end
  end
`else
  logic valid_b_q;

  assign data_d    = sample_a;
  assign valid_b_q = valid_a_q;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase_q   <= '0;
      phase_a_q <= '0;
      sel_a_q   <= '0;
      lut_a_q   <= '0;
      valid_a_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      phase_q <= phase_d;
      if (advance) begin
        phase_a_q <= phase_q[phase_width_p-1 -: width_p+1];
        sel_a_q   <= wave_sel_i;
        lut_a_q   <= lut[addr_r];
        valid_a_q <= 1'b1;
        valid_q   <= valid_b_q;
        data_q    <= data_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
